// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FPU format converters.
//   EXP_BIAS, IEEE-754 single field widths/positions, integer saturation
//   limits, the float-fields struct and the operand class used between
//   pipeline stages of the converters.
package fpu_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = FRAC_W + 1;
  localparam int SIGN_POS = 31;
  localparam int EXP_LSB  = FRAC_W;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = '1;

  localparam logic [31:0] INT_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;
  // -2^31 as a float: the one e=31 value that still fits an int32.
  localparam logic [31:0] FLT_INT_MIN = 32'hCF00_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } float_t;

  typedef enum logic [2:0] {
    CLS_ZERO,     // |x| < 0.5 by exponent alone (incl. zero/denormal)
    CLS_FINITE,   // e in -1..30, goes through shift and round
    CLS_SAT,      // e >= 31 or Inf: saturate by sign, overflow flagged
    CLS_NAN,      // NaN: positive saturation, overflow flagged
    CLS_INT_MIN   // exactly -2^31: representable, no overflow
  } cls_e;

endpackage

// File: rtl/fpu_rne.sv
// fpu_rne: round-to-nearest, ties-to-even increment decision.
//   lsb    - ulp bit of the truncated result
//   guard  - first bit below the ulp (the half bit)
//   round  - second bit below the ulp
//   sticky - OR of all remaining lower bits
//   inc    - add one ulp to the truncated magnitude
module fpu_rne (
  input  logic lsb,
  input  logic guard,
  input  logic round,
  input  logic sticky,
  output logic inc
);

  // Above half rounds up; exactly half rounds up only when lsb is odd.
  assign inc = guard & (round | sticky | lsb);

endmodule

// File: rtl/ftoi_pipe.sv
// ftoi_pipe: IEEE-754 single to signed 32-bit integer, RNE, saturating.
//   clk       - rising-edge clock
//   rstn      - asynchronous active-low reset
//   in_valid  - in_data holds an operand
//   in_ready  - operand accepted this cycle (global advance)
//   in_data   - {sign, exp[7:0], frac[22:0]}
//   out_valid - out_data/out_ovf hold a result
//   out_ready - consumer takes the result this cycle
//   out_data  - two's-complement integer result
//   out_ovf   - result saturated (out of range, Inf or NaN)
// Three register stages: classify -> barrel shift -> round/negate/saturate.
module ftoi_pipe
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf
);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  function automatic logic [32:0] sat_result(input cls_e cls, input logic sign,
                                             input logic [31:0] mag);
    logic signed [31:0] smag;
    logic signed [31:0] res;
    smag = signed'(mag);
    res  = sign ? -smag : smag;
    case (cls)
      CLS_ZERO:    return {1'b0, 32'h0};
      CLS_FINITE:  return {1'b0, res};
      CLS_INT_MIN: return {1'b0, INT_MIN};
      CLS_NAN:     return {1'b1, INT_MAX};
      default:     return {1'b1, sign ? INT_MIN : INT_MAX};
    endcase
  endfunction

  // ---- S1: unpack, classify, shift amount ----
  float_t      f_in;
  cls_e        cls_s1;
  logic [4:0]  shamt_s1;

  assign f_in = float_t'(in_data);

  always_comb begin
    cls_s1   = CLS_FINITE;
    // Left-shift distance that places the value's 0.5 bit at the guard position.
    shamt_s1 = 5'(f_in.exp - 8'(EXP_BIAS - 1));
    if (f_in.exp == EXP_SPECIAL)
      cls_s1 = (f_in.frac != '0) ? CLS_NAN : CLS_SAT;
    else if (in_data == FLT_INT_MIN)
      cls_s1 = CLS_INT_MIN;
    else if (f_in.exp >= 8'(EXP_BIAS + 31))
      cls_s1 = CLS_SAT;
    else if (f_in.exp < 8'(EXP_BIAS - 1))
      cls_s1 = CLS_ZERO;
  end

  logic              vld_p0;
  logic              sign_p0;
  cls_e              cls_p0;
  logic [MANT_W-1:0] mant_p0;
  logic [4:0]        shamt_p0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        vld_p0 <= 1'b0;
    else if (advance) vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      sign_p0  <= f_in.sign;
      cls_p0   <= cls_s1;
      mant_p0  <= {1'b1, f_in.frac};
      shamt_p0 <= shamt_s1;
    end
  end

  // ---- S2: barrel shift into integer part, guard, round, sticky ----
  // Window = 32 integer bits above 26 fraction bits; with shift 0 (e=-1)
  // the hidden bit lands on the guard (0.5) position.
  logic [57:0] win_s2;
  assign win_s2 = {32'b0, mant_p0, 2'b0} << shamt_p0;

  logic        vld_p1;
  logic        sign_p1;
  cls_e        cls_p1;
  logic [31:0] int_p1;
  logic        guard_p1;
  logic        round_p1;
  logic        sticky_p1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        vld_p1 <= 1'b0;
    else if (advance) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      sign_p1   <= sign_p0;
      cls_p1    <= cls_p0;
      int_p1    <= win_s2[57:26];
      guard_p1  <= win_s2[25];
      round_p1  <= win_s2[24];
      sticky_p1 <= |win_s2[23:0];
    end
  end

  // ---- S3: round magnitude, negate, saturate into output registers ----
  logic        rnd_inc;
  logic [31:0] mag_s3;
  logic [31:0] res_s3;
  logic        ovf_s3;

  fpu_rne u_rne (
    .lsb    (int_p1[0]),
    .guard  (guard_p1),
    .round  (round_p1),
    .sticky (sticky_p1),
    .inc    (rnd_inc)
  );

  // Magnitude is below 2^31 for every e<=30 input, so the carry cannot overflow.
  assign mag_s3           = int_p1 + {31'b0, rnd_inc};
  assign {ovf_s3, res_s3} = sat_result(cls_p1, sign_p1, mag_s3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_data <= res_s3;
        out_ovf  <= ovf_s3;
      end
    end
  end

endmodule
